// File: rtl/ram_fifo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : ram_fifo_ctrl
//  Purpose  : In-order FIFO controller over an external read-registered
//             simple dual-port RAM, with a 2-entry first-word-fall-through
//             output buffer.
//  Revision : 1.0 - initial release
// ============================================================================
module ram_fifo_ctrl #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 2048,
    parameter int ADDR_BITS = 11
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [WIDTH-1:0]       s_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [WIDTH-1:0]       m_data,
    output logic [ADDR_BITS+1:0]   count,
    output logic                   full,
    output logic                   empty,
    output logic                   ram_we,
    output logic [ADDR_BITS-1:0]   ram_w_addr,
    output logic [WIDTH-1:0]       ram_w_data,
    output logic [ADDR_BITS-1:0]   ram_r_addr,
    input  logic [WIDTH-1:0]       ram_r_data
);

    localparam logic [ADDR_BITS:0]   c_depth   = (ADDR_BITS+1)'(DEPTH);
    localparam logic [ADDR_BITS:0]   c_cnt_one = (ADDR_BITS+1)'(1);
    localparam logic [ADDR_BITS-1:0] c_last    = ADDR_BITS'(DEPTH - 1);
    localparam logic [ADDR_BITS-1:0] c_ptr_one = ADDR_BITS'(1);

    logic [ADDR_BITS-1:0] r_wr_ptr;
    logic [ADDR_BITS-1:0] r_rd_ptr;
    logic [ADDR_BITS:0]   r_ram_cnt;
    logic                 r_pend;
    logic [1:0]           r_buf_cnt;
    logic [WIDTH-1:0]     r_buf0;
    logic [WIDTH-1:0]     r_buf1;

    logic                 w_push;
    logic                 w_pop;
    logic                 w_rd;
    logic [2:0]           w_occ;
    logic [1:0]           w_tail;
    logic [1:0]           w_buf_cnt_nxt;
    logic [WIDTH-1:0]     w_buf0_nxt;
    logic [WIDTH-1:0]     w_buf1_nxt;

    assign s_ready = (r_ram_cnt < c_depth);
    assign m_valid = (r_buf_cnt != 2'd0);
    assign full    = ~s_ready;
    assign empty   = ~m_valid;
    assign m_data  = r_buf0;

    assign w_push  = s_valid && s_ready;
    assign w_pop   = m_valid && m_ready;

    // Occupancy the buffer will have once this cycle's pop and landing read settle.
    assign w_occ   = {1'b0, r_buf_cnt} + {2'b00, r_pend} - {2'b00, w_pop};
    assign w_rd    = (r_ram_cnt != '0) && (w_occ < 3'd2);

    assign ram_we     = w_push && rst_n;
    assign ram_w_addr = r_wr_ptr;
    assign ram_w_data = s_data;
    assign ram_r_addr = r_rd_ptr;

    assign count = (ADDR_BITS+2)'(r_ram_cnt)
                 + (ADDR_BITS+2)'(r_pend)
                 + (ADDR_BITS+2)'(r_buf_cnt);

    always_comb begin
        w_tail        = r_buf_cnt - {1'b0, w_pop};
        w_buf0_nxt    = w_pop ? r_buf1 : r_buf0;
        w_buf1_nxt    = r_buf1;
        // Returning RAM word lands behind whatever survives this cycle's pop.
        if (r_pend) begin
            if (w_tail == 2'd0) begin
                w_buf0_nxt = ram_r_data;
            end else begin
                w_buf1_nxt = ram_r_data;
            end
        end
        w_buf_cnt_nxt = w_tail + {1'b0, r_pend};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_ram_cnt <= '0;
            r_pend    <= 1'b0;
            r_buf_cnt <= 2'd0;
            r_buf0    <= '0;
            r_buf1    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == c_last) ? '0 : r_wr_ptr + c_ptr_one;
            end
            if (w_rd) begin
                r_rd_ptr <= (r_rd_ptr == c_last) ? '0 : r_rd_ptr + c_ptr_one;
            end
            if (w_push && !w_rd) begin
                r_ram_cnt <= r_ram_cnt + c_cnt_one;
            end else if (!w_push && w_rd) begin
                r_ram_cnt <= r_ram_cnt - c_cnt_one;
            end
            r_pend    <= w_rd;
            r_buf_cnt <= w_buf_cnt_nxt;
            r_buf0    <= w_buf0_nxt;
            r_buf1    <= w_buf1_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ram_fifo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ram_fifo_ctrl
//  Purpose  : Scoreboard bench for ram_fifo_ctrl (DEPTH=5 and DEPTH=4 copies).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ram_fifo_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic       a_s_valid, a_s_ready, a_m_valid, a_m_ready, a_full, a_empty, a_ram_we;
    logic [7:0] a_s_data, a_m_data, a_ram_w_data, a_ram_r_data;
    logic [4:0] a_count;
    logic [2:0] a_ram_w_addr, a_ram_r_addr;
    logic [7:0] a_mem [0:7];

    logic       b_s_valid, b_s_ready, b_m_valid, b_m_ready, b_full, b_empty, b_ram_we;
    logic [7:0] b_s_data, b_m_data, b_ram_w_data, b_ram_r_data;
    logic [3:0] b_count;
    logic [1:0] b_ram_w_addr, b_ram_r_addr;
    logic [7:0] b_mem [0:3];

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] q_a [$];
    logic [7:0] q_b [$];

    ram_fifo_ctrl #(.WIDTH(8), .DEPTH(5), .ADDR_BITS(3)) u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .s_valid(a_s_valid), .s_ready(a_s_ready), .s_data(a_s_data),
        .m_valid(a_m_valid), .m_ready(a_m_ready), .m_data(a_m_data),
        .count(a_count), .full(a_full), .empty(a_empty),
        .ram_we(a_ram_we), .ram_w_addr(a_ram_w_addr), .ram_w_data(a_ram_w_data),
        .ram_r_addr(a_ram_r_addr), .ram_r_data(a_ram_r_data)
    );

    ram_fifo_ctrl #(.WIDTH(8), .DEPTH(4), .ADDR_BITS(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .s_valid(b_s_valid), .s_ready(b_s_ready), .s_data(b_s_data),
        .m_valid(b_m_valid), .m_ready(b_m_ready), .m_data(b_m_data),
        .count(b_count), .full(b_full), .empty(b_empty),
        .ram_we(b_ram_we), .ram_w_addr(b_ram_w_addr), .ram_w_data(b_ram_w_data),
        .ram_r_addr(b_ram_r_addr), .ram_r_data(b_ram_r_data)
    );

    always @(posedge clk) begin
        if (a_ram_we) a_mem[a_ram_w_addr] <= a_ram_w_data;
        a_ram_r_data <= a_mem[a_ram_r_addr];
        if (b_ram_we) b_mem[b_ram_w_addr] <= b_ram_w_data;
        b_ram_r_data <= b_mem[b_ram_r_addr];
    end

    task automatic step_a(input logic sv, input logic [7:0] sd, input logic mr,
                          output logic acc, output logic got, output logic [7:0] dat);
        @(negedge clk);
        a_s_valid = sv; a_s_data = sd; a_m_ready = mr;
        #1;
        acc = a_s_valid && a_s_ready;
        got = a_m_valid && a_m_ready;
        dat = a_m_data;
    endtask

    task automatic step_b(input logic sv, input logic [7:0] sd, input logic mr,
                          output logic acc, output logic got, output logic [7:0] dat);
        @(negedge clk);
        b_s_valid = sv; b_s_data = sd; b_m_ready = mr;
        #1;
        acc = b_s_valid && b_s_ready;
        got = b_m_valid && b_m_ready;
        dat = b_m_data;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a_s_valid = 1'b1; a_s_data = 8'h3C; a_m_ready = 1'b0;
        b_s_valid = 1'b1; b_s_data = 8'h3C; b_m_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_tests++; if (a_ram_we !== 1'b0) begin n_fail++; $display("FAIL reset_ram_we: got %b expected 0", a_ram_we); end
        n_tests++; if (b_ram_we !== 1'b0) begin n_fail++; $display("FAIL reset_ram_we_b: got %b expected 0", b_ram_we); end
        n_tests++; if (a_s_ready !== 1'b1) begin n_fail++; $display("FAIL reset_s_ready: got %b expected 1", a_s_ready); end
        n_tests++; if (a_m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid: got %b expected 0", a_m_valid); end
        n_tests++; if (a_count !== 5'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", a_count); end
        n_tests++; if (a_full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b expected 0", a_full); end
        n_tests++; if (a_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b expected 1", a_empty); end
        n_tests++; if (a_m_data !== 8'h00) begin n_fail++; $display("FAIL reset_m_data: got %h expected 00", a_m_data); end
        n_tests++; if (b_count !== 4'd0) begin n_fail++; $display("FAIL reset_count_b: got %0d expected 0", b_count); end
        @(negedge clk);
        a_s_valid = 1'b0; b_s_valid = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_latency();
        logic acc, got;
        logic [7:0] dat, exp;
        step_a(1'b1, 8'hA5, 1'b0, acc, got, dat);
        n_tests++; if (acc !== 1'b1) begin n_fail++; $display("FAIL lat_accept: got %b expected 1", acc); end
        if (acc) q_a.push_back(8'hA5);
        for (int k = 0; k < 3; k++) begin
            step_a(1'b0, 8'h00, 1'b0, acc, got, dat);
            n_tests++; if (a_m_valid !== (k == 2)) begin n_fail++; $display("FAIL lat_m_valid[%0d]: got %b expected %b", k, a_m_valid, (k == 2)); end
            n_tests++; if (a_count !== 5'd1) begin n_fail++; $display("FAIL lat_count[%0d]: got %0d expected 1", k, a_count); end
            if (k == 2) begin
                n_tests++; if (a_m_data !== 8'hA5) begin n_fail++; $display("FAIL lat_m_data: got %h expected a5", a_m_data); end
            end
        end
        step_a(1'b0, 8'h00, 1'b1, acc, got, dat);
        n_tests++;
        if (!got || q_a.size() == 0) begin
            n_fail++; $display("FAIL lat_drain: got pop=%b expected 1", got);
        end else begin
            exp = q_a.pop_front();
            if (dat !== exp) begin n_fail++; $display("FAIL lat_drain_data: got %h expected %h", dat, exp); end
        end
        step_a(1'b0, 8'h00, 1'b0, acc, got, dat);
        n_tests++; if (a_empty !== 1'b1) begin n_fail++; $display("FAIL lat_empty_after: got %b expected 1", a_empty); end
    endtask

    task automatic test_stream();
        logic acc, got;
        logic [7:0] dat, exp;
        int sent = 0, recv = 0, first = -1, last = -1, stalls = 0;
        for (int i = 0; i < 300 && recv < 100; i++) begin
            step_a(sent < 100, sent[7:0], 1'b1, acc, got, dat);
            n_tests++; if (a_count !== 5'(q_a.size())) begin n_fail++; $display("FAIL stream_count[%0d]: got %0d expected %0d", i, a_count, q_a.size()); end
            if (sent < 100 && !acc) stalls++;
            if (acc) begin q_a.push_back(sent[7:0]); sent++; end
            if (got) begin
                n_tests++;
                if (q_a.size() == 0) begin
                    n_fail++; $display("FAIL stream_spurious: got %h expected no word", dat);
                end else begin
                    exp = q_a.pop_front();
                    if (dat !== exp) begin n_fail++; $display("FAIL stream_data: got %h expected %h", dat, exp); end
                end
                if (first < 0) first = i;
                last = i;
                recv++;
            end
        end
        n_tests++; if (recv != 100) begin n_fail++; $display("FAIL stream_recv: got %0d expected 100", recv); end
        n_tests++; if (stalls != 0) begin n_fail++; $display("FAIL stream_stalls: got %0d expected 0", stalls); end
        n_tests++; if (first != 3) begin n_fail++; $display("FAIL stream_first_cycle: got %0d expected 3", first); end
        n_tests++; if (last != 102) begin n_fail++; $display("FAIL stream_last_cycle: got %0d expected 102", last); end
    endtask

    task automatic test_full();
        logic acc, got;
        logic [7:0] dat, exp, d;
        int drained = 0;
        for (int i = 0; i < 6; i++) begin
            d = 8'h40 + 8'(i);
            step_b(1'b1, d, 1'b0, acc, got, dat);
            n_tests++; if (acc !== 1'b1) begin n_fail++; $display("FAIL full_accept[%0d]: got %b expected 1", i, acc); end
            if (acc) q_b.push_back(d);
        end
        for (int k = 0; k < 2; k++) begin
            step_b(1'b1, 8'hEE, 1'b0, acc, got, dat);
            n_tests++; if (acc !== 1'b0) begin n_fail++; $display("FAIL full_7th_accept[%0d]: got %b expected 0", k, acc); end
            n_tests++; if (b_full !== 1'b1) begin n_fail++; $display("FAIL full_flag[%0d]: got %b expected 1", k, b_full); end
            n_tests++; if (b_count !== 4'd6) begin n_fail++; $display("FAIL full_count[%0d]: got %0d expected 6", k, b_count); end
        end
        for (int i = 0; i < 30 && q_b.size() != 0; i++) begin
            step_b(1'b0, 8'h00, 1'b1, acc, got, dat);
            if (i == 1) begin
                n_tests++; if (b_s_ready !== 1'b1) begin n_fail++; $display("FAIL full_reopen: got %b expected 1", b_s_ready); end
            end
            if (got) begin
                exp = q_b.pop_front();
                drained++;
                n_tests++; if (dat !== exp) begin n_fail++; $display("FAIL full_drain_data: got %h expected %h", dat, exp); end
            end
        end
        n_tests++; if (drained != 6) begin n_fail++; $display("FAIL full_drain_count: got %0d expected 6", drained); end
        step_b(1'b0, 8'h00, 1'b0, acc, got, dat);
        n_tests++; if (b_count !== 4'd0 || b_empty !== 1'b1) begin n_fail++; $display("FAIL full_empty_after: got count=%0d empty=%b expected 0/1", b_count, b_empty); end
    endtask

    task automatic test_random();
        logic acc, got, sv, mr;
        logic [7:0] dat, exp, d;
        int sent = 0, recv = 0;
        for (int c = 0; c < 50000 && recv < 10000; c++) begin
            sv = (sent < 10000) && ($urandom_range(0, 1) == 1);
            mr = ($urandom_range(0, 1) == 1);
            d  = 8'($urandom);
            step_a(sv, d, mr, acc, got, dat);
            n_tests++; if (a_count !== 5'(q_a.size())) begin n_fail++; $display("FAIL rand_count[%0d]: got %0d expected %0d", c, a_count, q_a.size()); end
            if (acc) begin q_a.push_back(d); sent++; end
            if (got) begin
                n_tests++;
                if (q_a.size() == 0) begin
                    n_fail++; $display("FAIL rand_spurious: got %h expected no word", dat);
                end else begin
                    exp = q_a.pop_front();
                    if (dat !== exp) begin n_fail++; $display("FAIL rand_data[%0d]: got %h expected %h", recv, dat, exp); end
                end
                recv++;
            end
        end
        n_tests++; if (recv != 10000) begin n_fail++; $display("FAIL rand_recv: got %0d expected 10000", recv); end
        step_a(1'b0, 8'h00, 1'b0, acc, got, dat);
        n_tests++; if (a_count !== 5'd0 || a_empty !== 1'b1) begin n_fail++; $display("FAIL rand_empty_after: got count=%0d empty=%b expected 0/1", a_count, a_empty); end
    endtask

    task automatic test_midreset();
        logic acc, got;
        logic [7:0] dat, d;
        int outs = 0;
        for (int i = 0; i < 3; i++) begin
            d = 8'h70 + 8'(i);
            step_a(1'b1, d, 1'b0, acc, got, dat);
            if (acc) q_a.push_back(d);
        end
        step_a(1'b0, 8'h00, 1'b0, acc, got, dat);
        n_tests++; if (a_count !== 5'd3) begin n_fail++; $display("FAIL mid_fill_count: got %0d expected 3", a_count); end
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        q_a.delete();
        n_tests++; if (a_count !== 5'd0) begin n_fail++; $display("FAIL mid_count: got %0d expected 0", a_count); end
        n_tests++; if (a_m_valid !== 1'b0) begin n_fail++; $display("FAIL mid_m_valid: got %b expected 0", a_m_valid); end
        n_tests++; if (a_s_ready !== 1'b1) begin n_fail++; $display("FAIL mid_s_ready: got %b expected 1", a_s_ready); end
        step_a(1'b1, 8'h11, 1'b0, acc, got, dat);
        if (acc) q_a.push_back(8'h11);
        for (int i = 0; i < 10 && outs == 0; i++) begin
            step_a(1'b0, 8'h00, 1'b1, acc, got, dat);
            if (got) begin
                outs++;
                n_tests++; if (dat !== 8'h11) begin n_fail++; $display("FAIL mid_first_out: got %h expected 11", dat); end
                if (q_a.size() != 0) void'(q_a.pop_front());
            end
        end
        n_tests++; if (outs != 1) begin n_fail++; $display("FAIL mid_out_seen: got %0d expected 1", outs); end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) a_mem[i] = 8'h00;
        for (int i = 0; i < 4; i++) b_mem[i] = 8'h00;
        rst_n = 1'b0;
        a_s_valid = 1'b0; a_s_data = 8'h00; a_m_ready = 1'b0;
        b_s_valid = 1'b0; b_s_data = 8'h00; b_m_ready = 1'b0;
        test_reset();
        test_latency();
        test_stream();
        test_full();
        test_random();
        test_midreset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
